ps2_key_decoder: RTL and testbench

Upstream stage of top_game. Receives PS/2 keyboard frames, validates them, tracks make/break scan codes and drives the level-held key[3:0] vector consumed by top_game (player_control, player_control_y, control_hp, game_content_top). Runs in the 65 MHz pixel clock domain. ps2_clk and ps2_data are asynchronous inputs.

---
 rtl/ps2_key_decoder_pkg.sv | 58 +++++
 rtl/ps2_key_decoder_if.sv | 15 +
 rtl/ps2_key_decoder_rx.sv | 144 ++++++++++++++
 rtl/ps2_key_decoder.sv | 80 ++++++++
 tb/tb_ps2_key_decoder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan codes, key indices, receiver state encoding and scan-code lookup.
// Optional build macro: ARROW_KEYS_EN adds the E0-prefixed arrow aliases to the lookup.
package ps2_key_decoder_pkg;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BAT   = 8'hAA;

  localparam logic [7:0] KEY_A      = 8'h1C;
  localparam logic [7:0] KEY_D      = 8'h23;
  localparam logic [7:0] KEY_W      = 8'h1D;
  localparam logic [7:0] KEY_SPACE  = 8'h29;
  localparam logic [7:0] ARROW_L    = 8'h6B;
  localparam logic [7:0] ARROW_R    = 8'h74;
  localparam logic [7:0] ARROW_U    = 8'h75;

  localparam logic [1:0] KEY_LEFT   = 2'd0;
  localparam logic [1:0] KEY_RIGHT  = 2'd1;
  localparam logic [1:0] KEY_JUMP   = 2'd2;
  localparam logic [1:0] KEY_ACTION = 2'd3;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t RX_IDLE   = 2'd0;
  localparam rx_state_t RX_DATA   = 2'd1;
  localparam rx_state_t RX_PARITY = 2'd2;
  localparam rx_state_t RX_STOP   = 2'd3;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } key_hit_t;

  function automatic key_hit_t lookup_key(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r = '0;
    if (!ext) begin
      case (code)
        KEY_A:     r = '{hit: 1'b1, idx: KEY_LEFT};
        KEY_D:     r = '{hit: 1'b1, idx: KEY_RIGHT};
        KEY_W:     r = '{hit: 1'b1, idx: KEY_JUMP};
        KEY_SPACE: r = '{hit: 1'b1, idx: KEY_ACTION};
        default:   r = '0;
      endcase
    end
`ifdef ARROW_KEYS_EN
    else begin
      case (code)
        ARROW_L: r = '{hit: 1'b1, idx: KEY_LEFT};
        ARROW_R: r = '{hit: 1'b1, idx: KEY_RIGHT};
        ARROW_U: r = '{hit: 1'b1, idx: KEY_JUMP};
        default: r = '0;
      endcase
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and decoded outputs of the key decoder.
// master = keyboard/consumer side, slave = decoder side.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  modport master (output ps2_clk, output ps2_data,
                  input  key, input rx_byte, input rx_valid, input frame_err);
  modport slave  (input  ps2_clk, input ps2_data,
                  output key, output rx_byte, output rx_valid, output frame_err);
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: synchronisers, ps2_clk glitch filter, frame FSM and inter-edge timeout.
// state  | meaning
// IDLE   | waiting for a start bit (data=0 on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then publish byte or flag error
module ps2_key_decoder_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int CLK_HZ     = 65_000_000,
  parameter int TIMEOUT_US = 1000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);

  localparam int TO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W      = $clog2(TO_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FL_LOAD = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] FL_ONE  = FW'(1);

  logic [1:0]      clk_sync_q, data_sync_q;
  logic            filt_q, filt_prev_q;
  logic [FW-1:0]   flt_cnt_q;
  logic            clk_s, data_s, strobe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      flt_cnt_q   <= FL_LOAD;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_prev_q <= filt_q;
      if (clk_s == filt_q) begin
        flt_cnt_q <= FL_LOAD;
      end else if (flt_cnt_q == '0) begin
        filt_q    <= clk_s;
        flt_cnt_q <= FL_LOAD;
      end else begin
        flt_cnt_q <= flt_cnt_q - FL_ONE;
      end
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign strobe = filt_prev_q & ~filt_q;

  rx_state_t       state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    to_d    = to_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (state_q != RX_IDLE && to_q != '0)
      to_d = to_q - TO_ONE;
    if (strobe) begin
      to_d = TO_LOAD;
      case (state_q)
        RX_IDLE: begin
          if (!data_s) begin
            state_d = RX_DATA;
            bit_d   = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = data_s;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (data_s && (^{shift_q, par_q})) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && to_q == '0) begin
      // No falling edge within the timeout window: abandon the frame.
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      shift_q <= 8'h00;
      bit_q   <= 3'd0;
      par_q   <= 1'b0;
      to_q    <= TO_LOAD;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      to_q    <= to_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign rx_byte_o   = byte_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: receives frames and holds the left/right/jump/action key levels.
// Optional build macro: ARROW_KEYS_EN maps E0 6B/74/75 onto left/right/jump.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int CLK_HZ     = 65_000_000,
  parameter int TIMEOUT_US = 1000,
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  ps2_key_decoder_if.slave bus
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  ps2_key_decoder_rx #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILTER_LEN (FILTER_LEN)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (bus.ps2_clk),
    .ps2_data_i  (bus.ps2_data),
    .rx_byte_o   (rx_byte),
    .rx_valid_o  (rx_valid),
    .frame_err_o (frame_err)
  );

  logic [3:0] key_q, key_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  key_hit_t   hit;

  assign hit = lookup_key(rx_byte, ext_q);

  always_comb begin
    key_d = key_q;
    brk_d = brk_q;
    ext_d = ext_q;
    if (rx_valid) begin
      case (rx_byte)
        CODE_BREAK: brk_d = 1'b1;
        CODE_EXT:   ext_d = 1'b1;
        CODE_BAT: begin
          key_d = 4'b0000;
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
        default: begin
          // Prefixes apply to exactly one following byte, mapped or not.
          brk_d = 1'b0;
          ext_d = 1'b0;
          if (hit.hit) key_d[hit.idx] = ~brk_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q <= 4'b0000;
      brk_q <= 1'b0;
      ext_q <= 1'b0;
    end else begin
      key_q <= key_d;
      brk_q <= brk_d;
      ext_q <= ext_d;
    end
  end

  assign bus.key       = key_q;
  assign bus.rx_byte   = rx_byte;
  assign bus.rx_valid  = rx_valid;
  assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames, monitor pops expected events.
module tb_ps2_key_decoder;

  localparam int HALF = 20;

`ifdef ARROW_KEYS_EN
  localparam logic ARROW = 1'b1;
`else
  localparam logic ARROW = 1'b0;
`endif

  logic clk;
  logic rst;
  ps2_key_decoder_if bus();

  ps2_key_decoder #(
    .CLK_HZ     (1_000_000),
    .TIMEOUT_US (200),
    .FILTER_LEN (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] data;
    logic [3:0] key;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         valid_cnt = 0;
  logic [3:0] cur_key = 4'b0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic err, input logic [7:0] data, input logic [3:0] key);
    ev_t e;
    e.err  = err;
    e.data = data;
    e.key  = key;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (30) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par, input logic [3:0] key_after);
    logic par;
    par = (~^b) ^ bad_par;
    push(bad_par, b, key_after);
    send_bits({1'b1, par, b, 1'b0}, 11);
    drain();
  endtask

  // Monitor: every rx_valid/frame_err pulse must match the next queued event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst && (bus.rx_valid || bus.frame_err)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {bus.rx_valid, bus.frame_err, bus.rx_byte}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {bus.rx_valid, bus.frame_err}, {~e.err, e.err});
          if (!e.err) begin
            chk("rx_byte", bus.rx_byte, e.data);
            valid_cnt++;
          end
          chk("key_before_update", bus.key, cur_key);
          @(negedge clk);
          chk("pulse_width", {bus.rx_valid, bus.frame_err}, 0);
          chk("key_after", bus.key, e.key);
          cur_key = e.key;
        end
      end
    end
  end

  initial begin
    int vc0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {bus.key, bus.rx_byte, bus.rx_valid, bus.frame_err}, 0);
    rst = 1'b1;
    repeat (20) @(posedge clk);

    send(8'h1C, 1'b0, 4'b0001);
    // Reset after start + 4 data bits of an 0x23 frame.
    send_bits({1'b1, 1'b0, 8'h23, 1'b0}, 5);
    repeat (5) @(posedge clk);
    rst = 1'b0;
    cur_key = 4'b0000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midframe_reset", {bus.key, bus.rx_byte, bus.rx_valid, bus.frame_err}, 0);
    rst = 1'b1;
    repeat (400) @(posedge clk);
    chk("no_err_after_abort", exp_q.size(), 0);

    vc0 = valid_cnt;
    send(8'h1C, 1'b0, 4'b0001);
    send(8'h23, 1'b0, 4'b0011);
    send(8'hF0, 1'b0, 4'b0011);
    send(8'h1C, 1'b0, 4'b0010);
    chk("valid_pulse_count", valid_cnt - vc0, 4);

    send(8'h29, 1'b1, 4'b0010);
    send(8'h29, 1'b0, 4'b1010);

    push(1'b1, 8'h00, 4'b1010);
    send_bits({1'b1, 1'b0, 8'h1D, 1'b0}, 4);
    drain();
    send(8'h1D, 1'b0, 4'b1110);

    send(8'h1C, 1'b0, 4'b1111);
    send(8'hAA, 1'b0, 4'b0000);

    send(8'hE0, 1'b0, 4'b0000);
    send(8'h6B, 1'b0, {3'b000, ARROW});
    send(8'hE0, 1'b0, {3'b000, ARROW});
    send(8'hF0, 1'b0, {3'b000, ARROW});
    send(8'h6B, 1'b0, 4'b0000);

    send(8'hF0, 1'b0, 4'b0000);
    send(8'h23, 1'b0, 4'b0000);
    send(8'h29, 1'b0, 4'b1000);
    send(8'h29, 1'b0, 4'b1000);
    send(8'hF0, 1'b0, 4'b1000);
    send(8'h15, 1'b0, 4'b1000);
    send(8'h1C, 1'b0, 4'b1001);
    send(8'hE0, 1'b0, 4'b1001);
    send(8'h1D, 1'b0, 4'b1001);
    send(8'hF0, 1'b0, 4'b1001);
    send(8'h29, 1'b0, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
